// File: rtl/display_scan_7seg_pkg.sv
// Shared segment encodings for the 4-digit scanned 7-segment driver.
// All patterns are active-low, bit order g..a (bit 0 = segment a).
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
   localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
   localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
   localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
   localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
   localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
   localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
   localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
   localparam logic [6:0] SEG_HEX_A = 7'b0001000;
   localparam logic [6:0] SEG_HEX_B = 7'b0000011;
   localparam logic [6:0] SEG_HEX_C = 7'b1000110;
   localparam logic [6:0] SEG_HEX_D = 7'b0100001;
   localparam logic [6:0] SEG_HEX_E = 7'b0000110;
   localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/display_scan_7seg_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_hex)
         4'h0: o_seg = SEG_HEX_0;
         4'h1: o_seg = SEG_HEX_1;
         4'h2: o_seg = SEG_HEX_2;
         4'h3: o_seg = SEG_HEX_3;
         4'h4: o_seg = SEG_HEX_4;
         4'h5: o_seg = SEG_HEX_5;
         4'h6: o_seg = SEG_HEX_6;
         4'h7: o_seg = SEG_HEX_7;
         4'h8: o_seg = SEG_HEX_8;
         4'h9: o_seg = SEG_HEX_9;
         4'hA: o_seg = SEG_HEX_A;
         4'hB: o_seg = SEG_HEX_B;
         4'hC: o_seg = SEG_HEX_C;
         4'hD: o_seg = SEG_HEX_D;
         4'hE: o_seg = SEG_HEX_E;
         4'hF: o_seg = SEG_HEX_F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_7seg.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-slot
// blanking and frame-aligned (tear-free) update of the displayed word.
module display_scan_7seg
   import seg7_pkg::*;
#(
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int BLANK_TICKS     = 500
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_data,
   input  logic        i_load,
   input  logic [3:0]  i_en,
   input  logic        i_sel7seg,
   output logic [3:0]  o_an,
   output logic [6:0]  o_seg,
   output logic        o_pending,
   output logic        o_frame_tick
);

   localparam int CW = $clog2(TICKS_PER_DIGIT);
   localparam logic [CW-1:0] TICK_LAST  = CW'(TICKS_PER_DIGIT - 1);
   localparam logic [CW-1:0] TICK_BLANK = CW'(BLANK_TICKS);

   logic [CW-1:0] r_tick;
   logic [1:0]    r_idx;
   logic [15:0]   r_staging;
   logic [15:0]   r_shadow;
   logic          r_pending;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_frame_tick;

   logic          w_wrap;
   logic          w_boundary;
   logic          w_blank;
   logic [3:0]    w_digit;
   logic [6:0]    w_hex_seg;
   logic [3:0]    w_an_nxt;
   logic [6:0]    w_seg_nxt;

   assign w_wrap     = (r_tick == TICK_LAST);
   assign w_boundary = w_wrap && (r_idx == 2'd3);
   assign w_blank    = (r_tick < TICK_BLANK);
   assign w_digit    = r_shadow[{r_idx, 2'b00} +: 4];

   hex_to_7seg u_hex_to_7seg (
      .i_hex (w_digit),
      .o_seg (w_hex_seg)
   );

   always_comb begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = SEG_BLANK;
      if (!w_blank) begin
         w_an_nxt = ~((4'b0001 << r_idx) & i_en);
         if (i_en[r_idx])
            w_seg_nxt = i_sel7seg ? w_hex_seg : SEG_DASH;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tick       <= '0;
         r_idx        <= 2'd0;
         r_staging    <= 16'h0000;
         r_shadow     <= 16'h0000;
         r_pending    <= 1'b0;
         r_an         <= 4'b1111;
         r_seg        <= SEG_BLANK;
         r_frame_tick <= 1'b0;
      end else begin
         r_tick       <= w_wrap ? '0 : r_tick + 1'b1;
         if (w_wrap)
            r_idx <= r_idx + 2'd1;
         r_an         <= w_an_nxt;
         r_seg        <= w_seg_nxt;
         r_frame_tick <= w_boundary;
         // Transfer uses the pre-edge staging value; a same-cycle load re-arms pending.
         if (w_boundary && r_pending) begin
            r_shadow  <= r_staging;
            r_pending <= 1'b0;
         end
         if (i_load) begin
            r_staging <= i_data;
            r_pending <= 1'b1;
         end
      end
   end

   assign o_an         = r_an;
   assign o_seg        = r_seg;
   assign o_pending    = r_pending;
   assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Bench for display_scan_7seg: directed scenarios plus random traffic, all
// outputs compared each cycle against a cycle-count based reference model.
module tb_display_scan_7seg;

   localparam int TPD   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = TPD * 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data;
   logic        load;
   logic [3:0]  en;
   logic        sel;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        pending;
   logic        frame_tick;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: cycles since reset release, plus staged/shown words
   int          m_n;
   logic [15:0] m_staging, m_shadow;
   logic        m_pending;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_ft;

   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   always #5 clk = ~clk;

   display_scan_7seg #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BLANK)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (data),
      .i_load       (load),
      .i_en         (en),
      .i_sel7seg    (sel),
      .o_an         (an),
      .o_seg        (seg),
      .o_pending    (pending),
      .o_frame_tick (frame_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0t cyc=%0d got=%h exp=%h", tag, $time, m_n, got, exp);
   endtask

   task automatic model_reset();
      m_n = 0; m_staging = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
      e_an = 4'b1111; e_seg = 7'h7F; e_ft = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".an"}, 32'(an), 32'(e_an));
      chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
      chk({tag, ".pending"}, 32'(pending), 32'(m_pending));
      chk({tag, ".ftick"}, 32'(frame_tick), 32'(e_ft));
   endtask

   // One clock: apply inputs off-edge, advance model at the edge, compare after it.
   task automatic step(input logic ld, input logic [15:0] d, input string tag);
      int cnt, idx;
      logic boundary;
      load = ld; data = d;
      @(posedge clk);
      cnt = m_n % TPD;
      idx = (m_n / TPD) % 4;
      boundary = (cnt == TPD - 1) && (idx == 3);
      if (cnt < BLANK) begin
         e_an = 4'b1111; e_seg = 7'h7F;
      end else begin
         e_an = ~(4'(1 << idx) & en);
         if (!en[idx])  e_seg = 7'h7F;
         else if (sel)  e_seg = hex_tab[(m_shadow >> (4 * idx)) & 16'hF];
         else           e_seg = 7'b0111111;
      end
      e_ft = boundary;
      if (boundary && m_pending) begin
         m_shadow = m_staging; m_pending = 1'b0;
      end
      if (ld) begin
         m_staging = d; m_pending = 1'b1;
      end
      m_n++;
      #1;
      check_all(tag);
   endtask

   task automatic run(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, tag);
   endtask

   // Leaves the model one edge before a frame boundary.
   task automatic to_boundary(input string tag);
      for (int i = 0; i < FRAME && (m_n % FRAME) != FRAME - 1; i++) step(1'b0, 16'h0, tag);
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; data = 16'h0; en = 4'hF; sel = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run(70, "scan0");

      step(1'b1, 16'h8F21, "load8f21");
      run(5, "pend8f21");
      chk("pend_set", 32'(pending), 32'd1);
      to_boundary("wait8f21");
      run(FRAME + 2, "show8f21");

      step(1'b1, 16'h1111, "ld1111");
      run(3, "gap");
      step(1'b1, 16'h2222, "ld2222");
      to_boundary("wait2222");
      run(FRAME, "show2222");

      step(1'b1, 16'h3333, "ld3333");
      to_boundary("wait3333");
      step(1'b1, 16'h4444, "ldbound");
      chk("pend_stays", 32'(pending), 32'd1);
      run(FRAME, "show3333");
      run(FRAME, "show4444");

      to_boundary("bndnopend");
      step(1'b1, 16'hABCD, "ldbound_np");
      run(FRAME + 3, "shownp");

      en = 4'b0101; sel = 1'b0;
      run(2 * FRAME, "dash0101");
      en = 4'hF; sel = 1'b1;

      step(1'b1, 16'h5A5A, "ldrst");
      while ((m_n % TPD) != 4) step(1'b0, 16'h0, "torst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      run(FRAME + 4, "post_rst");

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 31) == 0) en = 4'($urandom);
         if ($urandom_range(0, 31) == 0) sel = 1'($urandom);
         step(1'($urandom_range(0, 15) == 0), 16'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/display_scan_7seg.md
Name: display_scan_7seg

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Sits directly downstream of the seven-segment selector logic: its SEL7SEG and per-digit enable outputs feed this block's SEL7SEG and EN inputs.
- Latches a 16-bit hex word via a load handshake and applies it only at frame boundaries, so the display never tears.
- Scans the digits in turn, with a blanking gap at the start of each digit slot to suppress ghosting.

Parameters:
- TICKS_PER_DIGIT, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_TICKS, 500, cycles at the start of each slot with all anodes off; must be < TICKS_PER_DIGIT.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DATA  input  16  four hex digits; digit i = DATA[4i+3:4i]; digit 0 is the rightmost, driven by AN[0].
- LOAD  input  1  single-cycle strobe; captures DATA into the staging register.
- EN  input  4  per-digit enable, active-high; EN[i]=0 keeps digit i dark.
- SEL7SEG  input  1  1 = show decoded hex; 0 = show dash on every enabled digit.
- AN  output  4  anode selects, active-low, at most one bit low.
- SEG  output  7  segments, active-low; SEG[0]=a ... SEG[6]=g.
- PENDING  output  1  high while staged data awaits a frame boundary.
- FRAME_TICK  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, RST_N=0) sets: AN=4'b1111, SEG=7'b1111111, PENDING=0, FRAME_TICK=0, staging=0, shadow=0, tick counter=0, digit index=0. It aborts any slot mid-scan. A pending load is discarded.
- Tick counter:
  - Width $clog2(TICKS_PER_DIGIT).
  - Counts 0..TICKS_PER_DIGIT-1, then wraps to 0.
  - On wrap, the digit index increments 0->1->2->3->0 (2-bit wrap).
- Frame boundary: the cycle where counter==TICKS_PER_DIGIT-1 and index==3.
- Outputs AN, SEG and FRAME_TICK are registered. Each cycle they load values computed from the current counter, index, shadow, EN and SEL7SEG, giving one cycle of latency.
- Blank phase (counter < BLANK_TICKS): next AN=4'b1111, next SEG=7'b1111111.
- Active phase:
  - Next AN = ~(onehot(index) & EN).
  - If EN[index]=0: SEG=7'b1111111.
  - Else if SEL7SEG=1: SEG=hex_decode(shadow digit[index]).
  - Else: SEG=SEG_DASH.
- EN and SEL7SEG are sampled every cycle. Changes take effect on the next cycle with no frame alignment.
- Load handshake:
  - LOAD=1: staging<=DATA and PENDING<=1 at that edge.
  - LOAD while PENDING=1: staging is overwritten (last load wins).
  - At a frame boundary with PENDING=1: shadow<=staging and PENDING<=0. The new shadow is used from digit 0 of the next frame.
  - LOAD on the boundary cycle itself: the transfer uses the pre-edge staging value. The new DATA is staged and PENDING stays 1 for the next frame.
  - LOAD on the boundary cycle with PENDING=0 beforehand: no transfer occurs; the new DATA is staged and PENDING=1.
- FRAME_TICK pulses high for one cycle, registered (one cycle after the boundary cycle), regardless of PENDING.
- hex_decode, active-low, g..a order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No decimal point; no combinational path from input to output.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111.
  - NUM_DIGITS=4.
  - The hex segment table constants.
- One sub-module: hex_to_7seg, combinational 4-bit in, 7-bit active-low out. It is instantiated once, fed by a mux of the shadow digit at the current index.

Test Plan (TICKS_PER_DIGIT=8, BLANK_TICKS=2):
- Reset, then RST_N=1 with EN=4'b1111, SEL7SEG=1 -> AN=1111 for the first 3 cycles. Then AN=1110 and SEG=1000000 ("0") for 6 cycles. Then AN=1111 for 2 cycles, then AN=1101. The sequence repeats with a 32-cycle period.
- LOAD=1 with DATA=16'h8F21 mid-frame -> PENDING=1 until the boundary. FRAME_TICK pulses one cycle after the boundary, PENDING drops to 0, and the next frame shows digits 0..3 as 1111001, 0100100, 0001110, 0000000.
- Two LOADs in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed after the boundary. LOAD on the boundary cycle itself -> old staged value shown, PENDING stays 1, new value shown one frame later.
- EN=4'b0101 with SEL7SEG=0 -> AN only ever goes to 1110 or 1011, with SEG=0111111. During the slots for digits 1 and 3, AN=1111 and SEG=1111111.
- Assert RST_N=0 mid active phase with PENDING=1 -> AN=1111, SEG=1111111 and PENDING=0 immediately (asynchronously). After release, scanning restarts at digit 0 and the display shows 0000.
